// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - stream, TX FIFO and status signals of the frame sequencer
interface frame_sequencer_if #(
    parameter int FIFO_WIDTH = 8
);
    logic [FIFO_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic [FIFO_WIDTH-1:0] pix_in;
    logic                  pix_in_valid;
    logic [FIFO_WIDTH-1:0] pix_out;
    logic                  pix_out_valid;
    logic [FIFO_WIDTH-1:0] tx_data;
    logic                  tx_wr;
    logic                  tx_full;
    logic                  busy;
    logic                  frame_done;
    logic                  err;

    modport master (
        input  rx_data, rx_valid, pix_out, pix_out_valid, tx_full,
        output pix_in, pix_in_valid, tx_data, tx_wr, busy, frame_done, err
    );

    modport slave (
        output rx_data, rx_valid, pix_out, pix_out_valid, tx_full,
        input  pix_in, pix_in_valid, tx_data, tx_wr, busy, frame_done, err
    );
endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - header parser, pixel forwarder, pipeline flusher and result framer
module frame_sequencer #(
    parameter int                    FIFO_WIDTH = 8,
    parameter int                    DIM_W      = 12,
    parameter int                    MAX_W      = 640,
    parameter int                    MAX_H      = 480,
    parameter int                    FLUSH_GAP  = 4,
    parameter int                    TIMEOUT    = 65535,
    parameter logic [FIFO_WIDTH-1:0] EOF_BYTE   = 8'hA5,
    parameter logic [FIFO_WIDTH-1:0] ERR_BYTE   = 8'hEE
) (
    input logic               clk,
    input logic               rstN,
    frame_sequencer_if.master bus
);
    localparam int CNT_W  = 2 * DIM_W;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = (FLUSH_GAP > 1) ? $clog2(FLUSH_GAP) : 1;

    typedef enum logic [2:0] {HDR0, HDR1, HDR2, HDR3, CHECK, STREAM, FLUSH, EOF} state_t;

    state_t             state, state_next;
    logic [DIM_W-1:0]   w_dim, h_dim;
    logic [CNT_W-1:0]   total, in_cnt, out_cnt;
    logic [IDLE_W-1:0]  idle;
    logic [GAP_W-1:0]   gap;
    logic               bad;

    logic hdr_ok, accept_out, inject, timeout_hit, last_pix;

    assign hdr_ok = (w_dim >= DIM_W'(3)) && (w_dim <= DIM_W'(MAX_W)) &&
                    (h_dim >= DIM_W'(3)) && (h_dim <= DIM_W'(MAX_H));
    // Results beyond total are the pipeline tail produced by flush pixels.
    assign accept_out  = bus.pix_out_valid && (out_cnt < total) &&
                         (state == STREAM || state == FLUSH);
    assign inject      = (state == FLUSH) && !bus.tx_full && (gap == GAP_W'(FLUSH_GAP - 1));
    assign timeout_hit = (state == FLUSH) && !bus.pix_out_valid && (idle == IDLE_W'(TIMEOUT - 1));
    assign last_pix    = bus.rx_valid && (in_cnt + CNT_W'(1) == total);

    always_ff @(posedge clk) begin
        if (!rstN) state <= HDR0;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HDR0:    if (bus.rx_valid) state_next = HDR1;
            HDR1:    if (bus.rx_valid) state_next = HDR2;
            HDR2:    if (bus.rx_valid) state_next = HDR3;
            HDR3:    if (bus.rx_valid) state_next = CHECK;
            CHECK:   state_next = hdr_ok ? STREAM : EOF;
            STREAM:  if (last_pix) state_next = FLUSH;
            FLUSH:   if (out_cnt == total || timeout_hit) state_next = EOF;
            EOF:     if (!bus.tx_full) state_next = HDR0;
            default: state_next = HDR0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            w_dim            <= '0;
            h_dim            <= '0;
            total            <= '0;
            in_cnt           <= '0;
            out_cnt          <= '0;
            idle             <= '0;
            gap              <= '0;
            bad              <= 1'b0;
            bus.pix_in       <= '0;
            bus.pix_in_valid <= 1'b0;
            bus.tx_data      <= '0;
            bus.tx_wr        <= 1'b0;
            bus.busy         <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            bus.pix_in_valid <= 1'b0;
            bus.tx_wr        <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.err          <= 1'b0;
            bus.busy         <= (state_next != HDR0);

            case (state)
                HDR0: if (bus.rx_valid) w_dim <= DIM_W'({bus.rx_data, FIFO_WIDTH'(0)});
                HDR1: if (bus.rx_valid) w_dim <= w_dim | DIM_W'(bus.rx_data);
                HDR2: if (bus.rx_valid) h_dim <= DIM_W'({bus.rx_data, FIFO_WIDTH'(0)});
                HDR3: if (bus.rx_valid) h_dim <= h_dim | DIM_W'(bus.rx_data);
                CHECK: begin
                    total   <= CNT_W'(w_dim) * CNT_W'(h_dim);
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    idle    <= '0;
                    gap     <= '0;
                    bad     <= !hdr_ok;
                end
                STREAM: if (bus.rx_valid) begin
                    bus.pix_in       <= bus.rx_data;
                    bus.pix_in_valid <= 1'b1;
                    in_cnt           <= in_cnt + CNT_W'(1);
                end
                FLUSH: begin
                    if (bus.rx_valid) bad <= 1'b1;
                    // The slot counter freezes while the TX FIFO is full.
                    if (!bus.tx_full) begin
                        if (inject) begin
                            gap              <= '0;
                            bus.pix_in       <= '0;
                            bus.pix_in_valid <= 1'b1;
                        end else begin
                            gap <= gap + GAP_W'(1);
                        end
                    end
                    idle <= bus.pix_out_valid ? '0 : idle + IDLE_W'(1);
                    if (timeout_hit) bad <= 1'b1;
                end
                EOF: begin
                    if (bus.rx_valid) bad <= 1'b1;
                    if (!bus.tx_full) begin
                        bus.tx_wr      <= 1'b1;
                        bus.tx_data    <= bad ? ERR_BYTE : EOF_BYTE;
                        bus.err        <= bad;
                        bus.frame_done <= !bad;
                    end
                end
                default: ;
            endcase

            if (accept_out) begin
                out_cnt <= out_cnt + CNT_W'(1);
                if (bus.tx_full) begin
                    bad <= 1'b1;
                end else begin
                    bus.tx_wr   <= 1'b1;
                    bus.tx_data <= bus.pix_out;
                end
            end
        end
    end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level controller between `uart_top` and `canny_edge_top` in the image-processing chip. It parses a 4-byte frame header from the UART RX stream and forwards exactly W×H pixels into the edge-detection pipeline. Once input ends, it injects zero pixels to flush the pipeline's line buffers. It forwards exactly W×H result pixels to the UART TX FIFO, then terminates the frame with a status byte.

## Interface
- `FIFO_WIDTH`, 8, pixel/byte width (from `definitions_pkg`)
- `DIM_W`, 12, width of each header dimension field
- `MAX_W`, 640, largest accepted frame width
- `MAX_H`, 480, largest accepted frame height
- `FLUSH_GAP`, 4, cycles between injected flush pixels
- `TIMEOUT`, 65535, idle-cycle limit while flushing
- `EOF_BYTE`, 8'hA5, status byte for a good frame
- `ERR_BYTE`, 8'hEE, status byte for a bad header or bad frame

Ports:
- `clk` in 1 — single clock
- `rstN` in 1 — synchronous, active-low reset
- `rx_data` in FIFO_WIDTH — byte from UART RX
- `rx_valid` in 1 — `rx_data` valid, one cycle per byte
- `pix_in` out FIFO_WIDTH — pixel to canny
- `pix_in_valid` out 1 — `pix_in` valid
- `pix_out` in FIFO_WIDTH — result pixel from canny
- `pix_out_valid` in 1 — `pix_out` valid; canny cannot stall
- `tx_data` out FIFO_WIDTH — byte to UART TX FIFO
- `tx_wr` out 1 — TX FIFO write strobe
- `tx_full` in 1 — TX FIFO full
- `busy` out 1 — high in every state except HDR0
- `frame_done` out 1 — one-cycle pulse when the EOF status byte is written
- `err` out 1 — one-cycle pulse when `ERR_BYTE` is written

## Operation
- States: HDR0, HDR1, HDR2, HDR3, CHECK, STREAM, FLUSH, EOF.
- **Header capture.** HDR0–HDR3 capture W_hi, W_lo, H_hi, H_lo on `rx_valid`.
  - W = {W_hi, W_lo}[DIM_W-1:0]; upper bits are ignored.
  - The same applies to H.
- **CHECK (one cycle).**
  - Registers `total` = W×H, 2·DIM_W bits, no overflow possible.
  - Clears `in_cnt`, `out_cnt` and the sticky `bad` flag.
  - Valid header: 3 ≤ W ≤ MAX_W and 3 ≤ H ≤ MAX_H. Go to STREAM.
  - Invalid header: set `bad` and go to EOF. No pixels are forwarded.
- **STREAM.**
  - Each `rx_valid` drives `pix_in` = `rx_data` with `pix_in_valid` = 1 on the next cycle, and increments `in_cnt`.
  - When `in_cnt` reaches `total` (on the last pixel), go to FLUSH.
- **FLUSH.**
  - Drives `pix_in` = 0 with `pix_in_valid` = 1 once every FLUSH_GAP cycles.
  - Injection happens only while `tx_full` = 0; the gap counter holds while `tx_full` = 1.
  - When `out_cnt` = `total`, go to EOF.
  - Idle counter: cleared on each `pix_out_valid`, incremented otherwise.
  - Idle counter reaching TIMEOUT sets `bad` and goes to EOF.
- **Output path (STREAM and FLUSH).**
  - `pix_out_valid` with `out_cnt` < `total`: write `pix_out` to TX next cycle and increment `out_cnt`.
  - If `tx_full` = 1 at that moment: drop the write, set `bad`, still increment `out_cnt`.
  - `pix_out_valid` with `out_cnt` ≥ `total` (pipeline tail) is discarded in every state.
- **EOF.**
  - Waits for `tx_full` = 0, then writes `ERR_BYTE` if `bad`, else `EOF_BYTE`.
  - Pulses `err` or `frame_done` to match.
  - Returns to HDR0.
- **Ignored input.** `rx_valid` in CHECK, FLUSH or EOF is dropped.
  - In FLUSH or EOF it also sets `bad`; this does not apply when the frame is already in EOF due to a bad header.
- **Flush pixel values.** Flush pixels are not tracked by `in_cnt`.

## Timing
- **Reset.** While `rstN` = 0 at a clock edge:
  - state → HDR0;
  - all counters and `bad` → 0;
  - `pix_in`, `pix_in_valid`, `tx_data`, `tx_wr`, `busy`, `frame_done`, `err` → 0.
- **Reset mid-frame.** Abandons the frame with no status byte. In-flight canny outputs after reset are discarded, because `total` = 0.
- **Latencies.**
  - `rx_valid` → `pix_in_valid`: 1 cycle.
  - `pix_out_valid` → `tx_wr`: 1 cycle.
  - All outputs are registered.
- **Header to stream.** Last header byte → STREAM: 2 cycles (HDR3 → CHECK → STREAM). A pixel arriving during CHECK is dropped; the host must leave ≥ 1 idle cycle, which UART byte spacing guarantees.
- **Simultaneous events.**
  - A pixel-result write and the EOF status write never coincide: EOF writes at least 1 cycle after the last result write.
  - In FLUSH, `tx_full` and a flush-slot expiry on the same cycle: no injection that cycle.
  - In STREAM, the final `rx_valid` and `pix_out_valid` on the same cycle: both are handled.
- **Throughput.** STREAM forwards up to 1 pixel per cycle.

## Test plan
- **Good 4×4 frame.** Header 00 04 00 04, then 16 ramp pixels 0..15 → exactly 16 `pix_in_valid` carrying 0..15, flush zeros after them, 16 TX result bytes, then `tx_data` = 8'hA5 with a one-cycle `frame_done`.
- **Invalid header.** Header 00 00 00 05 (W = 0) → no `pix_in_valid`, TX byte 8'hEE with `err`, back in HDR0; a following valid 3×3 frame completes with 8'hA5.
- **`tx_full` during flush.** 8×8 frame with `tx_full` held high for 50 FLUSH cycles while canny outputs are silent → no flush injections during the hold; injection resumes with FLUSH_GAP spacing; frame ends with 8'hA5.
- **Timeout.** Canny model stops producing after 10 of 16 outputs, with TIMEOUT set to 100 → 8'hEE written 100 idle cycles later; `err` pulses; state returns to HDR0.
- **Overrun.** `tx_full` = 1 on the cycle a result arrives → that write is suppressed, `out_cnt` still advances, and the frame ends with 8'hEE.
- **Reset mid-stream.** Reset after 7 of 16 pixels of a 4×4 frame → all outputs 0 next cycle, `busy` = 0, no status byte; late canny outputs produce no `tx_wr`; the next header is parsed correctly.
